sequential_divider: RTL

- Sequential signed (two's complement) divider; the arithmetic inverse of the sequential multiplier.
- Takes a 2*DW-bit dividend (e.g. a product) and a DW-bit divisor.
- Uses restoring division on magnitudes, one quotient bit per clock.
- Returns a truncated-toward-zero quotient and remainder, plus a Ready strobe.
- Sits beside the multiplier, after the start one-shot; its outputs feed the BCD/7-segment display path.

---
 rtl/sequential_divider.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - signed restoring divider, one quotient bit per clock
//
// Ports:
//   clk            rising-edge system clock
//   rst            synchronous active-high reset
//   start          one-cycle request, honoured in IDLE and DONE only
//   Dividend_INPUT 2*DW-bit signed dividend
//   Divisor_INPUT  DW-bit signed divisor
//   Busy           high in LOAD, CALC and SIGN
//   Ready          high in DONE (result valid)
//   Quotient       2*DW-bit signed quotient, truncated toward zero
//   Remainder      DW-bit signed remainder, sign of the dividend
//   DivZero        divisor was zero for the current result
//   Overflow       -2^(2DW-1) / -1 (quotient wraps to 2^(2DW-1))
module sequential_divider #(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*DW-1:0]   Dividend_INPUT,
    input  logic [DW-1:0]     Divisor_INPUT,
    output logic              Busy,
    output logic              Ready,
    output logic [2*DW-1:0]   Quotient,
    output logic [DW-1:0]     Remainder,
    output logic              DivZero,
    output logic              Overflow
);
    localparam int QW = 2 * DW;
    localparam int CW = $clog2(QW);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, SIGN, DONE} state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   dividend_q, dividend_d;
    logic [DW-1:0]   divisor_q, divisor_d;
    // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB.
    logic [QW-1:0]   qsh_q, qsh_d;
    // Divisor magnitude fits DW bits unsigned (largest is 2^(DW-1)).
    logic [DW-1:0]   dmag_q, dmag_d;
    // Partial remainder stays below dmag, so DW bits suffice between iterations.
    logic [DW-1:0]   prem_q, prem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q_q, sign_q_d;
    logic            sign_r_q, sign_r_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic [QW-1:0]   quot_q, quot_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            divzero_q, divzero_d;
    logic            ovf_q, ovf_d;

    logic [DW:0]     shifted;
    logic [DW-1:0]   trial;
    logic            fits;

    always_comb begin
        state_d   = state_q;
        dividend_d = dividend_q;
        divisor_d = divisor_q;
        qsh_d     = qsh_q;
        dmag_d    = dmag_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        sign_q_d  = sign_q_q;
        sign_r_d  = sign_r_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divzero_d = divzero_q;
        ovf_d     = ovf_q;

        shifted = {prem_q, qsh_q[QW-1]};
        fits    = (shifted >= {1'b0, dmag_q});
        // Only consumed when fits is set, where the true difference is below 2^DW.
        trial   = shifted[DW-1:0] - dmag_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dividend_d = Dividend_INPUT;
                    divisor_d  = Divisor_INPUT;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (divisor_q == '0) begin
                    divzero_d = 1'b1;
                    quot_d    = '0;
                    rem_d     = '0;
                    ovf_d     = 1'b0;
                    state_d   = DONE;
                end else begin
                    qsh_d    = dividend_q[QW-1] ? -dividend_q : dividend_q;
                    dmag_d   = divisor_q[DW-1] ? -divisor_q : divisor_q;
                    sign_q_d = dividend_q[QW-1] ^ divisor_q[DW-1];
                    sign_r_d = dividend_q[QW-1];
                    prem_d   = '0;
                    cnt_d    = CW'(QW - 1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                prem_d = fits ? trial : shifted[DW-1:0];
                qsh_d  = {qsh_q[QW-2:0], fits};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                quot_d    = sign_q_q ? -qsh_q : qsh_q;
                rem_d     = sign_r_q ? -prem_q : prem_q;
                // Only -2^(QW-1) / -1 yields a positive magnitude of 2^(QW-1).
                ovf_d     = !sign_q_q && (qsh_q == {1'b1, {(QW-1){1'b0}}});
                divzero_d = 1'b0;
                state_d   = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == LOAD) || (state_d == CALC) || (state_d == SIGN);
        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            qsh_q      <= '0;
            dmag_q     <= '0;
            prem_q     <= '0;
            cnt_q      <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            divzero_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            qsh_q      <= qsh_d;
            dmag_q     <= dmag_d;
            prem_q     <= prem_d;
            cnt_q      <= cnt_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divzero_q  <= divzero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign Busy      = busy_q;
    assign Ready     = ready_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivZero   = divzero_q;
    assign Overflow  = ovf_q;
endmodule
